// File: rtl/mux_onehot.sv
// ---------------------------------------------------------------------------
// mux_onehot
//
// One-hot-select multiplexer with a one-deep registered output stage and a
// sticky select-legality monitor. The datapath is a plain AND-OR reduction:
// every word is gated by its select bit and the gated words are ORed. There
// is no priority, so a multi-hot select yields the OR of the selected words.
//
// Parameters
//   InputWidth  number of data words and width of the one-hot select (>= 1)
//   DataWidth   bits per data word (>= 1)
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset (registered outputs only)
//   sel_i         one-hot select, bit i picks data_i[i]
//   data_i        packed array of InputWidth words
//   valid_i       qualifies sel_i/data_i for the register stage and monitor
//   err_clr_i     synchronous clear of err_sticky_o (a same-cycle set wins)
//   data_o        combinational mux result
//   sel_zero_o    combinational, no select bit set
//   sel_multi_o   combinational, two or more select bits set
//   data_q_o      data_o captured on edges where valid_i=1, held otherwise
//   valid_q_o     valid_i delayed by one cycle
//   err_sticky_o  set once an illegal select is seen while valid_i=1
//
// Build option
//   MUX_ONEHOT_ASSERT_EN  when defined, compiles simulation-only checks that
//                         a valid select is one-hot and that both
//                         parameters are at least 1. Logic and ports are the
//                         same either way.
// ---------------------------------------------------------------------------
module mux_onehot #(
    parameter int InputWidth = 8,
    parameter int DataWidth  = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [InputWidth-1:0]                 sel_i,
    input  logic [InputWidth-1:0][DataWidth-1:0]  data_i,
    input  logic                                  valid_i,
    input  logic                                  err_clr_i,
    output logic [DataWidth-1:0]                  data_o,
    output logic                                  sel_zero_o,
    output logic                                  sel_multi_o,
    output logic [DataWidth-1:0]                  data_q_o,
    output logic                                  valid_q_o,
    output logic                                  err_sticky_o
);

    // Running chains indexed by "words examined so far". Entry 0 is the
    // empty prefix; entry InputWidth covers the whole select vector.
    logic [InputWidth:0][DataWidth-1:0] or_chain;
    logic [InputWidth:0]                seen_one;
    logic [InputWidth:0]                seen_two;

    assign or_chain[0] = '0;
    assign seen_one[0] = 1'b0;
    assign seen_two[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < InputWidth; gi++) begin : g_chain
            assign or_chain[gi+1] = or_chain[gi] | (data_i[gi] & {DataWidth{sel_i[gi]}});
            assign seen_one[gi+1] = seen_one[gi] | sel_i[gi];
            // A second set bit is detected when a bit is set after one was
            // already seen; no population count needed. With one input this
            // reduces to a constant 0.
            assign seen_two[gi+1] = seen_two[gi] | (seen_one[gi] & sel_i[gi]);
        end
    endgenerate

    assign data_o      = or_chain[InputWidth];
    assign sel_zero_o  = ~seen_one[InputWidth];
    assign sel_multi_o = seen_two[InputWidth];

    // Register stage and sticky error flag
    logic [DataWidth-1:0] data_q_reg;
    logic [DataWidth-1:0] data_q_next;
    logic                 valid_q_reg;
    logic                 err_sticky_reg;
    logic                 err_sticky_next;
    logic                 err_set;

    assign err_set = valid_i & (sel_zero_o | sel_multi_o);

    always_comb begin
        data_q_next     = data_q_reg;
        if (valid_i) begin
            data_q_next = data_o;
        end
        // Set has priority over a simultaneous clear so no event is lost.
        err_sticky_next = err_set | (err_sticky_reg & ~err_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q_reg     <= '0;
            valid_q_reg    <= 1'b0;
            err_sticky_reg <= 1'b0;
        end else begin
            data_q_reg     <= data_q_next;
            valid_q_reg    <= valid_i;
            err_sticky_reg <= err_sticky_next;
        end
    end

    assign data_q_o     = data_q_reg;
    assign valid_q_o    = valid_q_reg;
    assign err_sticky_o = err_sticky_reg;

`ifdef MUX_ONEHOT_ASSERT_EN
    generate
        if (InputWidth < 1 || DataWidth < 1) begin : g_param_check
            $error("mux_onehot: InputWidth and DataWidth must both be >= 1");
        end
    endgenerate

    a_sel_onehot : assert property (
        @(posedge clk_i) disable iff (!rst_ni) valid_i |-> $onehot(sel_i)
    ) else $error("mux_onehot: select not one-hot, sel_i=%b", sel_i);
`else
    // Checks disabled: nothing extra is compiled.
`endif

endmodule

// File: tb/tb_mux_onehot.sv
module tb_mux_onehot;

    localparam int IW = 8;
    localparam int DW = 8;

    logic                   clk_i;
    logic                   rst_ni;
    logic [IW-1:0]          sel_i;
    logic [IW-1:0][DW-1:0]  data_i;
    logic                   valid_i;
    logic                   err_clr_i;
    logic [DW-1:0]          data_o;
    logic                   sel_zero_o;
    logic                   sel_multi_o;
    logic [DW-1:0]          data_q_o;
    logic                   valid_q_o;
    logic                   err_sticky_o;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Scoreboard of expected data_q_o values, pushed when a valid word is driven.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_hold;

    mux_onehot #(.InputWidth(IW), .DataWidth(DW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .sel_i        (sel_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .err_clr_i    (err_clr_i),
        .data_o       (data_o),
        .sel_zero_o   (sel_zero_o),
        .sel_multi_o  (sel_multi_o),
        .data_q_o     (data_q_o),
        .valid_q_o    (valid_q_o),
        .err_sticky_o (err_sticky_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic randomize_data();
        for (int i = 0; i < IW; i++) data_i[i] = DW'($urandom);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; sel_i = '0; valid_i = 1'b0; err_clr_i = 1'b0;
        randomize_data();
        repeat (2) @(negedge clk_i);
        sel_i = 8'b0000_1000;
        #1;
        check_cnt++;
        if ({data_q_o, valid_q_o, err_sticky_o} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL reset_regs: got data_q=%h valid_q=%b err=%b, want 00 0 0", data_q_o, valid_q_o, err_sticky_o);
        else pass_cnt++;
        check_cnt++;
        if (data_o !== data_i[3])
            $display("FAIL reset_comb: got data_o=%h, want %h", data_o, data_i[3]);
        else pass_cnt++;
        $display("reset: data_q=%h valid_q=%b err=%b data_o=%h", data_q_o, valid_q_o, err_sticky_o, data_o);
        @(negedge clk_i);
        rst_ni = 1'b1;
        exp_hold = 8'h00;
    endtask

    task automatic test_random_onehot();
        logic [DW-1:0] exp_d;
        logic [DW-1:0] got;
        int            k;
        int            errs = 0;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk_i);
            k = int'($urandom_range(0, IW - 1));
            randomize_data();
            sel_i   = IW'(1) << k;
            valid_i = 1'b1;
            exp_d   = data_i[k];
            exp_q.push_back(exp_d);
            exp_hold = exp_d;
            #1;
            check_cnt++;
            if (data_o !== exp_d || sel_zero_o !== 1'b0 || sel_multi_o !== 1'b0) begin
                $display("FAIL onehot_comb: k=%0d got data_o=%h zero=%b multi=%b, want %h 0 0", k, data_o, sel_zero_o, sel_multi_o, exp_d);
                errs++;
            end else pass_cnt++;
            @(posedge clk_i); #1;
            got = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
            check_cnt++;
            if (data_q_o !== got || valid_q_o !== 1'b1) begin
                $display("FAIL onehot_reg: got data_q=%h valid_q=%b, want %h 1", data_q_o, valid_q_o, got);
                errs++;
            end else pass_cnt++;
        end
        $display("random_onehot: 10000 transactions, %0d errors", errs);
        check_cnt++;
        if (err_sticky_o !== 1'b0)
            $display("FAIL onehot_no_err: got err=%b, want 0", err_sticky_o);
        else pass_cnt++;
    endtask

    task automatic test_edges();
        logic [IW-1:0] sels [2];
        logic [DW-1:0] exps [2];
        sels[0] = 8'b0000_0001; exps[0] = 8'hA5;
        sels[1] = 8'b1000_0000; exps[1] = 8'h3C;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk_i);
            randomize_data();
            data_i[0] = 8'hA5; data_i[7] = 8'h3C;
            sel_i = sels[t]; valid_i = 1'b0;
            #1;
            check_cnt++;
            if (data_o !== exps[t])
                $display("FAIL edge_sel: sel=%b got data_o=%h, want %h", sel_i, data_o, exps[t]);
            else pass_cnt++;
            $display("edge: sel=%b data_o=%h", sel_i, data_o);
        end
        @(posedge clk_i); #1;
        check_cnt++;
        if (data_q_o !== exp_hold || valid_q_o !== 1'b0)
            $display("FAIL edge_hold: got data_q=%h valid_q=%b, want %h 0", data_q_o, valid_q_o, exp_hold);
        else pass_cnt++;
    endtask

    task automatic test_zero_select();
        logic [DW-1:0] got;
        @(negedge clk_i);
        randomize_data();
        sel_i = '0; valid_i = 1'b1;
        exp_q.push_back(8'h00);
        exp_hold = 8'h00;
        #1;
        check_cnt++;
        if (data_o !== 8'h00 || sel_zero_o !== 1'b1 || sel_multi_o !== 1'b0)
            $display("FAIL zero_comb: got data_o=%h zero=%b multi=%b, want 00 1 0", data_o, sel_zero_o, sel_multi_o);
        else pass_cnt++;
        @(posedge clk_i); #1;
        got = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        check_cnt++;
        if (err_sticky_o !== 1'b1 || data_q_o !== got)
            $display("FAIL zero_err: got err=%b data_q=%h, want 1 %h", err_sticky_o, data_q_o, got);
        else pass_cnt++;
        $display("zero_select: data_o=%h err=%b", data_o, err_sticky_o);
    endtask

    task automatic test_multi_hot();
        logic [DW-1:0] got;
        @(negedge clk_i);
        randomize_data();
        data_i[0] = 8'h0F; data_i[2] = 8'hF0;
        sel_i = 8'b0000_0101; valid_i = 1'b1;
        exp_q.push_back(8'hFF);
        exp_hold = 8'hFF;
        #1;
        check_cnt++;
        if (data_o !== 8'hFF || sel_multi_o !== 1'b1 || sel_zero_o !== 1'b0)
            $display("FAIL multi_comb: got data_o=%h multi=%b zero=%b, want ff 1 0", data_o, sel_multi_o, sel_zero_o);
        else pass_cnt++;
        @(posedge clk_i); #1;
        got = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        check_cnt++;
        if (data_q_o !== got)
            $display("FAIL multi_reg: got data_q=%h, want %h", data_q_o, got);
        else pass_cnt++;
        // Set and clear in the same cycle: set wins.
        @(negedge clk_i);
        sel_i = 8'b1100_0000; valid_i = 1'b1; err_clr_i = 1'b1;
        exp_hold = data_i[6] | data_i[7];
        @(posedge clk_i); #1;
        check_cnt++;
        if (err_sticky_o !== 1'b1)
            $display("FAIL set_wins: got err=%b, want 1", err_sticky_o);
        else pass_cnt++;
        // Clear with valid low.
        @(negedge clk_i);
        valid_i = 1'b0; err_clr_i = 1'b1;
        @(posedge clk_i); #1;
        check_cnt++;
        if (err_sticky_o !== 1'b0)
            $display("FAIL err_clear: got err=%b, want 0", err_sticky_o);
        else pass_cnt++;
        // Illegal select while not valid must not set the flag.
        @(negedge clk_i);
        err_clr_i = 1'b0; sel_i = '0; valid_i = 1'b0;
        @(posedge clk_i); #1;
        check_cnt++;
        if (err_sticky_o !== 1'b0 || data_q_o !== exp_hold)
            $display("FAIL err_needs_valid: got err=%b data_q=%h, want 0 %h", err_sticky_o, data_q_o, exp_hold);
        else pass_cnt++;
        $display("multi_hot: err=%b data_q=%h", err_sticky_o, data_q_o);
    endtask

    task automatic test_register_stage();
        logic [DW-1:0] got;
        @(negedge clk_i);
        randomize_data();
        data_i[1] = 8'h5A;
        sel_i = 8'b0000_0010; valid_i = 1'b1;
        exp_q.push_back(8'h5A);
        exp_hold = 8'h5A;
        @(posedge clk_i); #1;
        got = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        check_cnt++;
        if (data_q_o !== got || valid_q_o !== 1'b1)
            $display("FAIL reg_capture: got data_q=%h valid_q=%b, want %h 1", data_q_o, valid_q_o, got);
        else pass_cnt++;
        @(negedge clk_i);
        randomize_data();
        sel_i = 8'b0001_0000; valid_i = 1'b0;
        @(posedge clk_i); #1;
        check_cnt++;
        if (data_q_o !== exp_hold || valid_q_o !== 1'b0)
            $display("FAIL reg_hold: got data_q=%h valid_q=%b, want %h 0", data_q_o, valid_q_o, exp_hold);
        else pass_cnt++;
        $display("register_stage: data_q=%h valid_q=%b", data_q_o, valid_q_o);
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] got;
        @(negedge clk_i);
        randomize_data();
        data_i[0] = 8'h11; data_i[1] = 8'h22;
        sel_i = 8'b0000_0011; valid_i = 1'b1;
        exp_q.push_back(8'h33);
        @(posedge clk_i); #2;
        got = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        check_cnt++;
        if (data_q_o !== got || valid_q_o !== 1'b1 || err_sticky_o !== 1'b1)
            $display("FAIL prereset_state: got data_q=%h valid_q=%b err=%b, want %h 1 1", data_q_o, valid_q_o, err_sticky_o, got);
        else pass_cnt++;
        rst_ni = 1'b0;
        #1;
        check_cnt++;
        if ({data_q_o, valid_q_o, err_sticky_o} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL async_reset: got data_q=%h valid_q=%b err=%b, want 00 0 0", data_q_o, valid_q_o, err_sticky_o);
        else pass_cnt++;
        sel_i = 8'b0010_0000;
        #1;
        check_cnt++;
        if (data_o !== data_i[5])
            $display("FAIL reset_tracks: got data_o=%h, want %h", data_o, data_i[5]);
        else pass_cnt++;
        $display("async_reset: data_q=%h valid_q=%b err=%b data_o=%h", data_q_o, valid_q_o, err_sticky_o, data_o);
        @(negedge clk_i);
        valid_i = 1'b0;
        rst_ni = 1'b1;
    endtask

    initial begin
        test_reset();
        test_random_onehot();
        test_edges();
        test_zero_select();
        test_multi_hot();
        test_register_stage();
        test_async_reset();
        repeat (2) @(negedge clk_i);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
